// File: rtl/base_arb_pkg.sv
// Shared arbiter types: grant state of a packet-locked arbiter.
// Combinational types only; no latency or flow control of its own.
package base_arb_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

endpackage

// File: rtl/base_gasket_arb_if.sv
// Requester-side and gasket-side beat buses of the gasket arbiter.
// Wires only: zero latency; ready flows from the gasket back to the requesters.
interface base_gasket_arb_if #(
  parameter int nreq      = 4,
  parameter int width     = 1,
  parameter int ewidth    = 1,
  parameter int ni        = 2,
  parameter int ni_width  = $clog2(ni + 1),
  parameter int sel_width = $clog2(nreq)
);
  logic [nreq-1:0]            r_v;
  logic [nreq-1:0]            r_r;
  logic [nreq*ni_width-1:0]   r_nv;
  logic [nreq*ni*width-1:0]   r_d;
  logic [nreq-1:0]            r_e;
  logic [nreq*ewidth-1:0]     r_ed;
  logic                       g_v;
  logic                       g_r;
  logic [ni_width-1:0]        g_nv;
  logic [ni*width-1:0]        g_d;
  logic                       g_e;
  logic [ewidth-1:0]          g_ed;
  logic [sel_width-1:0]       g_id;

  // master: requesters plus gasket ready; slave: the arbiter itself
  modport master (
    output r_v, r_nv, r_d, r_e, r_ed, g_r,
    input  r_r, g_v, g_nv, g_d, g_e, g_ed, g_id
  );

  modport slave (
    input  r_v, r_nv, r_d, r_e, r_ed, g_r,
    output r_r, g_v, g_nv, g_d, g_e, g_ed, g_id
  );
endinterface

// File: rtl/base_rr_pick.sv
// Rotate-priority encoder: first set req at or after ptr, wrapping at nreq.
// Purely combinational; idx is 0 when no request is set.
module base_rr_pick #(
  parameter int nreq      = 4,
  parameter int sel_width = $clog2(nreq)
) (
  input  logic [nreq-1:0]      req,
  input  logic [sel_width-1:0] ptr,
  output logic                 any,
  output logic [sel_width-1:0] idx
);

  int                   cand;
  logic [sel_width-1:0] cand_s;

  // Scan from farthest to nearest so the nearest hit to ptr overwrites the rest.
  always_comb begin
    any    = |req;
    idx    = '0;
    cand   = 0;
    cand_s = '0;
    for (int k = nreq - 1; k >= 0; k--) begin
      cand = int'(ptr) + k;
      if (cand >= nreq) begin
        cand = cand - nreq;
      end
      cand_s = sel_width'(cand);
      if (req[cand_s]) begin
        idx = cand_s;
      end
    end
  end

endmodule

// File: rtl/base_gasket_arb.sv
// Packet-locked round-robin arbiter in front of one gasket input; zero latency.
// Grant is held from first beat to accepted end beat; g_r is steered to the owner only.
module base_gasket_arb
  import base_arb_pkg::*;
#(
  parameter int nreq      = 4,
  parameter int width     = 1,
  parameter int ewidth    = 1,
  parameter int ni        = 2,
  parameter int ni_width  = $clog2(ni + 1),
  parameter int sel_width = $clog2(nreq)
) (
  input  logic              clk,
  input  logic              reset,
  base_gasket_arb_if.slave  bus,
  output logic              busy
);

  arb_state_t           state_q, state_d;
  logic [sel_width-1:0] owner_q, owner_d;
  logic [sel_width-1:0] rr_ptr_q, rr_ptr_d;

  logic                 win_any;
  logic [sel_width-1:0] win_idx;
  logic [sel_width-1:0] sel;
  logic                 accept;
  logic                 end_acc;

  // Non-power-of-2 nreq must wrap explicitly rather than by overflow.
  function automatic logic [sel_width-1:0] ptr_inc(input logic [sel_width-1:0] p);
    return (p == sel_width'(nreq - 1)) ? '0 : p + sel_width'(1);
  endfunction

  base_rr_pick #(
    .nreq      (nreq),
    .sel_width (sel_width)
  ) u_pick (
    .req (bus.r_v),
    .ptr (rr_ptr_q),
    .any (win_any),
    .idx (win_idx)
  );

  always_comb begin
    sel = (state_q == LOCK) ? owner_q : win_idx;
  end

  always_comb begin
    bus.g_v = 1'b0;
    if (reset) begin
      bus.g_v = (state_q == LOCK) ? bus.r_v[owner_q] : win_any;
    end
  end

  always_comb begin
    bus.r_r = '0;
    for (int i = 0; i < nreq; i++) begin
      bus.r_r[i] = bus.g_r & reset & (sel == sel_width'(i));
    end
  end

  // Requester 0 occupies the most significant slice of every packed field.
  always_comb begin
    bus.g_nv = bus.r_nv[(nreq-1)*ni_width +: ni_width];
    bus.g_d  = bus.r_d[(nreq-1)*ni*width +: ni*width];
    bus.g_ed = bus.r_ed[(nreq-1)*ewidth +: ewidth];
    bus.g_e  = bus.r_e[0];
    for (int i = 0; i < nreq; i++) begin
      if (sel == sel_width'(i)) begin
        bus.g_nv = bus.r_nv[(nreq-1-i)*ni_width +: ni_width];
        bus.g_d  = bus.r_d[(nreq-1-i)*ni*width +: ni*width];
        bus.g_ed = bus.r_ed[(nreq-1-i)*ewidth +: ewidth];
        bus.g_e  = bus.r_e[i];
      end
    end
    bus.g_id = sel;
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    accept   = bus.g_v & bus.g_r;
    end_acc  = accept & bus.g_e;
    case (state_q)
      IDLE: begin
        if (end_acc) begin
          rr_ptr_d = ptr_inc(win_idx);
        end else if (bus.g_v) begin
          // An unaccepted first beat also locks, keeping the offered beat stable.
          state_d = LOCK;
          owner_d = win_idx;
        end
      end
      LOCK: begin
        if (end_acc) begin
          state_d  = IDLE;
          rr_ptr_d = ptr_inc(owner_q);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign busy = (state_q == LOCK);

endmodule
